// File: rtl/alu_ctrl_seq.sv
// ============================================================================
// Module   : alu_ctrl_seq
// Brief    : Registered ALU control decode with a multi-cycle mul/div sequencer
//            between instruction decode and the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [3:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              Jr_o,
    output logic              illegal_o,
    output logic              mdu_start_o,
    output logic              mdu_op_o
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT);

    // Counter is loaded with LAT-2 so the return edge lands LAT cycles after accept.
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 2);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT - 2);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic               r_op;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_jr;
    logic               r_illegal;

    logic [3:0]         w_code;
    logic               w_jr;
    logic               w_illegal;
    logic               w_multi;
    logic               w_div;
    logic               w_ready;
    logic               w_accept;

    always_comb begin
        w_code    = 4'b0000;
        w_jr      = 1'b0;
        w_illegal = 1'b0;
        w_multi   = 1'b0;
        w_div     = 1'b0;
        case (ALUOp_i)
            4'b0010: begin
                case (funct_i)
                    6'b100001: w_code = 4'b0010;
                    6'b100011: w_code = 4'b0110;
                    6'b100100: w_code = 4'b0000;
                    6'b100101: w_code = 4'b0001;
                    6'b101010: w_code = 4'b0111;
                    6'b000011: w_code = 4'b1110;
                    6'b000111: w_code = 4'b1111;
                    6'b001000: begin
                        w_code = 4'b0100;
                        w_jr   = 1'b1;
                    end
                    6'b011000: begin
                        w_code  = 4'b0011;
                        w_multi = 1'b1;
                    end
                    6'b011010: begin
                        w_code  = 4'b0101;
                        w_multi = 1'b1;
                        w_div   = 1'b1;
                    end
                    default:   w_illegal = 1'b1;
                endcase
            end
            4'b0100: w_code = 4'b0010;
            4'b0101: w_code = 4'b0111;
            4'b0001: w_code = 4'b0110;
            4'b0110: w_code = 4'b1101;
            4'b1100: w_code = 4'b1000;
            4'b0111: w_code = 4'b0001;
            4'b0011: w_code = 4'b0110;
            4'b1000: w_code = 4'b0010;
            4'b1001: w_code = 4'b0010;
            4'b0000: w_code = 4'b0000;
            4'b1010: w_code = 4'b0110;
            4'b1011: w_code = 4'b0110;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_ready  = (r_state == c_ST_IDLE);
    assign w_accept = valid_i & w_ready & ~flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_start_nxt = 1'b0;
        if (flush_i) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            w_state_nxt = c_ST_BUSY;
                            w_cnt_nxt   = w_div ? c_DIV_LOAD : c_MUL_LOAD;
                            w_start_nxt = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_IDLE;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            r_op      <= 1'b0;
            r_ctrl    <= '0;
            r_jr      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_start <= w_start_nxt;
            // Control codes hold across BUSY and flushes until the next accept.
            if (w_accept) begin
                r_ctrl    <= CTRL_W'(w_code);
                r_jr      <= w_jr;
                r_illegal <= w_illegal;
                if (w_multi) begin
                    r_op <= w_div;
                end
            end
        end
    end

    assign ready_o     = w_ready;
    assign valid_o     = r_valid;
    assign ALUCtrl_o   = r_ctrl;
    assign Jr_o        = r_jr;
    assign illegal_o   = r_illegal;
    assign mdu_start_o = r_start;
    assign mdu_op_o    = r_op;

endmodule

`default_nettype wire
